// File: rtl/car_motion_ctrl.sv
// rtl/car_motion_ctrl.sv - per-frame heading/speed/position update producing VGA camera scroll
// Samples buttons on each synchronised vsync falling edge and walks a 4-state update pipeline.
module car_motion_ctrl #(
    parameter int MAP_W           = 320,
    parameter int MAP_H           = 240,
    parameter int HALF_VIEW_X     = 160,
    parameter int HALF_VIEW_Y     = 120,
    parameter int START_X         = 160,
    parameter int START_Y         = 120,
    parameter int MAX_SPEED       = 4,
    parameter int ACCEL_FRAMES    = 4,
    parameter int FRICTION_FRAMES = 8,
    parameter int TURN_FRAMES     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [9:0] scroll_x,
    output logic [9:0] scroll_y,
    output logic [3:0] degree,
    output logic [2:0] speed,
    output logic       frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_INPUT, S_MOVE, S_CLAMP, S_OUT} state_t;

    localparam logic [3:0] ACC_P  = 4'(ACCEL_FRAMES);
    localparam logic [3:0] FRIC_P = 4'(FRICTION_FRAMES);
    localparam logic [3:0] TURN_P = 4'(TURN_FRAMES);
    localparam logic [2:0] MAX_P  = 3'(MAX_SPEED);
    localparam logic [9:0] LIM_X  = 10'(MAP_W - 1);
    localparam logic [9:0] LIM_Y  = 10'(MAP_H - 1);

    function automatic logic [7:0] sin_lut(input logic [3:0] d);
        case (d)
            4'd0, 4'd8:   sin_lut = 8'd0;
            4'd1, 4'd7:   sin_lut = 8'd24;
            4'd2, 4'd6:   sin_lut = 8'd45;
            4'd3, 4'd5:   sin_lut = 8'd59;
            4'd4:         sin_lut = 8'd64;
            4'd9, 4'd15:  sin_lut = -8'sd24;
            4'd10, 4'd14: sin_lut = -8'sd45;
            4'd11, 4'd13: sin_lut = -8'sd59;
            default:      sin_lut = -8'sd64;
        endcase
    endfunction

    // MSB flags that a clamp happened; low 16 bits are the clamped Q10.6 position.
    function automatic logic [16:0] clamp_axis(input logic [16:0] n, input logic [9:0] lim);
        if (n[16])
            clamp_axis = {1'b1, 16'd0};
        else if (n[15:6] > lim)
            clamp_axis = {1'b1, lim, 6'd0};
        else
            clamp_axis = {1'b0, n[15:0]};
    endfunction

    logic [1:0]  vs_q;
    logic        vs_prev_q;
    logic [3:0]  btn_s1_q, btn_s2_q;
    logic        frame_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q      <= 2'b11;
            vs_prev_q <= 1'b1;
            btn_s1_q  <= 4'd0;
            btn_s2_q  <= 4'd0;
        end else begin
            vs_q      <= {vs_q[0], vsync};
            vs_prev_q <= vs_q[1];
            btn_s1_q  <= {btn_up, btn_down, btn_left, btn_right};
            btn_s2_q  <= btn_s1_q;
        end
    end

    assign frame_edge = vs_prev_q & ~vs_q[1];

    state_t      state_q;
    logic [3:0]  btn_q;
    logic [3:0]  deg_q, deg_d;
    logic [3:0]  turn_q, turn_d;
    logic [2:0]  spd_q, spd_d;
    logic [3:0]  spd_cnt_q, spd_cnt_d;
    logic [1:0]  pedal_q, pedal_d;
    logic [15:0] pos_x_q, pos_y_q;
    logic [16:0] nx_q, ny_q, nx_d, ny_d;
    logic [16:0] cx, cy;
    logic [3:0]  period, cnt_eff;
    logic signed [10:0] sx, sy, sp, dx, dy;

    always_comb begin
        deg_d  = deg_q;
        turn_d = 4'd0;
        if (btn_q[1] ^ btn_q[0]) begin
            if (turn_q == 4'd0)
                deg_d = btn_q[0] ? deg_q + 4'd1 : deg_q - 4'd1;
            turn_d = (turn_q == TURN_P - 4'd1) ? 4'd0 : turn_q + 4'd1;
        end

        // Brake wins over throttle; a pedal change restarts the rate counter.
        pedal_d = btn_q[2] ? 2'd2 : (btn_q[3] ? 2'd1 : 2'd0);
        period  = (pedal_d == 2'd0) ? FRIC_P : ACC_P;
        cnt_eff = (pedal_d != pedal_q) ? 4'd0 : spd_cnt_q;
        spd_d   = spd_q;
        if (cnt_eff == 4'd0) begin
            if (pedal_d == 2'd1) begin
                if (spd_q < MAX_P) spd_d = spd_q + 3'd1;
            end else if (spd_q != 3'd0) begin
                spd_d = spd_q - 3'd1;
            end
        end
        spd_cnt_d = (cnt_eff == period - 4'd1) ? 4'd0 : cnt_eff + 4'd1;

        sx   = 11'($signed(sin_lut(deg_q)));
        sy   = 11'($signed(sin_lut(deg_q + 4'd4)));
        sp   = {8'd0, spd_q};
        dx   = sx * sp;
        dy   = -(sy * sp);
        nx_d = {1'b0, pos_x_q} + {{6{dx[10]}}, dx};
        ny_d = {1'b0, pos_y_q} + {{6{dy[10]}}, dy};

        cx = clamp_axis(nx_q, LIM_X);
        cy = clamp_axis(ny_q, LIM_Y);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            btn_q      <= 4'd0;
            deg_q      <= 4'd0;
            turn_q     <= 4'd0;
            spd_q      <= 3'd0;
            spd_cnt_q  <= 4'd0;
            pedal_q    <= 2'd0;
            pos_x_q    <= {10'(START_X), 6'd0};
            pos_y_q    <= {10'(START_Y), 6'd0};
            nx_q       <= 17'd0;
            ny_q       <= 17'd0;
            scroll_x   <= 10'(START_X - HALF_VIEW_X);
            scroll_y   <= 10'(START_Y - HALF_VIEW_Y);
            degree     <= 4'd0;
            speed      <= 3'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (frame_edge) begin
                        btn_q   <= btn_s2_q;
                        state_q <= S_INPUT;
                    end
                end
                S_INPUT: begin
                    deg_q     <= deg_d;
                    turn_q    <= turn_d;
                    spd_q     <= spd_d;
                    spd_cnt_q <= spd_cnt_d;
                    pedal_q   <= pedal_d;
                    state_q   <= S_MOVE;
                end
                S_MOVE: begin
                    nx_q    <= nx_d;
                    ny_q    <= ny_d;
                    state_q <= S_CLAMP;
                end
                S_CLAMP: begin
                    pos_x_q <= cx[15:0];
                    pos_y_q <= cy[15:0];
                    if (cx[16] || cy[16]) begin
                        spd_q     <= 3'd0;
                        spd_cnt_q <= 4'd0;
                    end
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    scroll_x   <= pos_x_q[15:6] - 10'(HALF_VIEW_X);
                    scroll_y   <= pos_y_q[15:6] - 10'(HALF_VIEW_Y);
                    degree     <= deg_q;
                    speed      <= spd_q;
                    frame_done <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb/tb_car_motion_ctrl.sv - directed and randomized frames against a behavioural car model
module tb_car_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vsync = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [9:0] scroll_x, scroll_y;
    logic [3:0] degree;
    logic [2:0] speed;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    car_motion_ctrl dut (
        .clk(clk), .rst(rst), .vsync(vsync),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .scroll_x(scroll_x), .scroll_y(scroll_y), .degree(degree), .speed(speed),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400us;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    // World state in 1/64 pixel units.
    int sinv[16] = '{0, 24, 45, 59, 64, 59, 45, 24, 0, -24, -45, -59, -64, -59, -45, -24};
    int mx, my, mdeg, mspd, mturn, mcnt, mped;
    bit mclx, mcly;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = 160 * 64; my = 120 * 64;
        mdeg = 0; mspd = 0; mturn = 0; mcnt = 0; mped = 0;
        mclx = 0; mcly = 0;
    endtask

    task automatic model_frame(input bit u, input bit d, input bit l, input bit r);
        int ped, per, c;
        if (l != r) begin
            if (mturn == 0) mdeg = (mdeg + (r ? 1 : 15)) % 16;
            mturn = (mturn + 1) % 3;
        end else begin
            mturn = 0;
        end
        ped = d ? 2 : (u ? 1 : 0);
        per = (ped == 0) ? 8 : 4;
        c = (ped != mped) ? 0 : mcnt;
        if (c == 0) begin
            if (ped == 1) mspd = (mspd < 4) ? mspd + 1 : 4;
            else          mspd = (mspd > 0) ? mspd - 1 : 0;
        end
        mcnt = (c + 1) % per;
        mped = ped;
        mx = mx + sinv[mdeg] * mspd;
        my = my - sinv[(mdeg + 4) % 16] * mspd;
        mclx = 0; mcly = 0;
        if (mx < 0) begin mx = 0; mclx = 1; end
        else if (mx / 64 > 319) begin mx = 319 * 64; mclx = 1; end
        if (my < 0) begin my = 0; mcly = 1; end
        else if (my / 64 > 239) begin my = 239 * 64; mcly = 1; end
        if (mclx || mcly) begin mspd = 0; mcnt = 0; end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_scroll_x"}, 32'(scroll_x), 32'((mx / 64 - 160) & 1023));
        check({tag, "_scroll_y"}, 32'(scroll_y), 32'((my / 64 - 120) & 1023));
        check({tag, "_degree"}, 32'(degree), 32'(mdeg));
        check({tag, "_speed"}, 32'(speed), 32'(mspd));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_scroll_x"}, 32'(scroll_x), 0);
        check({tag, "_scroll_y"}, 32'(scroll_y), 0);
        check({tag, "_degree"}, 32'(degree), 0);
        check({tag, "_speed"}, 32'(speed), 0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; vsync = 1'b1;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        #1 check_reset_vals("reset_asserted");
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        model_reset();
        repeat (6) @(posedge clk);
        #1 check_reset_vals("reset_released");
    endtask

    task automatic run_frame(input bit u, input bit d, input bit l, input bit r, input string tag);
        int lat;
        bit got;
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        repeat (4) @(posedge clk);
        @(negedge clk) vsync = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            lat++;
            if (frame_done === 1'b1) got = 1;
        end
        check({tag, "_latency"}, 32'(lat), 7);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(frame_done), 0);
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(posedge clk);
        model_frame(u, d, l, r);
        check_outputs(tag);
    endtask

    int exp_spd[5] = '{1, 1, 1, 1, 2};
    int exp_sy[5]  = '{1023, 1022, 1021, 1020, 1018};

    initial begin
        int n;
        int dones;
        logic [9:0] hold_x, hold_y;
        bit u, d, l, r;

        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_vals("initial_reset");
        @(negedge clk) rst = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_reset_vals("no_edge_hold");

        // Throttle from standstill heading up.
        for (int i = 0; i < 5; i++) begin
            run_frame(1, 0, 0, 0, "accel");
            check("accel_speed_const", 32'(speed), 32'(exp_spd[i]));
            check("accel_scroll_y_const", 32'(scroll_y), 32'(exp_sy[i]));
            check("accel_scroll_x_const", 32'(scroll_x), 0);
        end

        do_reset();

        do_reset();
        run_frame(0, 0, 0, 1, "steer_right");
        check("steer_right_const", 32'(degree), 1);
        do_reset();
        run_frame(0, 0, 1, 0, "steer_left");
        check("steer_left_wrap_const", 32'(degree), 15);
        run_frame(0, 0, 1, 1, "steer_both");
        check("steer_both_const", 32'(degree), 15);

        // Drive into the right wall, turn round, drive into the left wall.
        do_reset();
        n = 0;
        while (mdeg != 4 && n < 20) begin run_frame(0, 0, 0, 1, "turn_e"); n++; end
        check("turn_e_reached", 32'(mdeg), 4);
        n = 0;
        mclx = 0;
        while (!mclx && n < 150) begin run_frame(1, 0, 0, 0, "drive_e"); n++; end
        check("clamp_e_scroll_x", 32'(scroll_x), 159);
        check("clamp_e_speed", 32'(speed), 0);
        n = 0;
        run_frame(0, 0, 0, 0, "settle");
        while (mdeg != 12 && n < 40) begin run_frame(0, 0, 0, 1, "turn_w"); n++; end
        check("turn_w_reached", 32'(mdeg), 12);
        n = 0;
        mclx = 0;
        while (!mclx && n < 200) begin run_frame(1, 0, 0, 0, "drive_w"); n++; end
        check("clamp_w_scroll_x", 32'(scroll_x), 864);
        check("clamp_w_speed", 32'(speed), 0);

        // Brake priority and friction to standstill.
        do_reset();
        n = 0;
        while (mspd != 3 && n < 20) begin run_frame(1, 0, 0, 0, "to_speed3"); n++; end
        check("to_speed3_const", 32'(speed), 3);
        run_frame(1, 1, 0, 0, "brake_wins");
        check("brake_wins_const", 32'(speed), 2);
        n = 0;
        while (mspd != 0 && n < 20) begin run_frame(0, 0, 0, 0, "friction"); n++; end
        check("friction_stop_const", 32'(speed), 0);
        hold_x = scroll_x; hold_y = scroll_y;
        for (int i = 0; i < 3; i++) begin
            run_frame(0, 0, 0, 0, "idle_stop");
            check("idle_stop_speed", 32'(speed), 0);
            check("idle_stop_x", 32'(scroll_x), 32'(hold_x));
            check("idle_stop_y", 32'(scroll_y), 32'(hold_y));
        end

        // Reset landing in the MOVE state kills the frame.
        run_frame(1, 0, 0, 1, "pre_abort");
        @(negedge clk) vsync = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_vals("abort_in_move");
        @(negedge clk) vsync = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        model_reset();
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) dones++;
        end
        check("abort_no_done", 32'(dones), 0);
        check_reset_vals("abort_after");

        // A second edge arriving while MOVE is active is ignored.
        @(negedge clk);
        btn_up = 1; btn_down = 0; btn_left = 0; btn_right = 0;
        repeat (4) @(posedge clk);
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) vsync = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) dones++;
        end
        @(negedge clk) vsync = 1'b1;
        repeat (20) @(posedge clk);
        #1 if (frame_done === 1'b1) dones++;
        check("double_edge_done_count", 32'(dones), 1);
        model_frame(1, 0, 0, 0);
        check_outputs("double_edge");

        // Randomized driving.
        for (int i = 0; i < 60; i++) begin
            u = ($urandom_range(0, 99) < 60);
            d = ($urandom_range(0, 99) < 15);
            l = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 30);
            run_frame(u, d, l, r, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
